// File: rtl/match_sram_pkg.sv
// Shared definitions for the searchable register file: default geometry and
// the encoding of the key-search state machine.
package match_sram_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } search_state_t;

endpackage

// File: rtl/match_sram_search.sv
// Sequential masked-key scanner: walks idx from 0 upward, stops on the first
// word whose compared bits equal the latched key, and reports the result.
module match_sram_search
    import match_sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] mask,
    input  logic [DATA_W-1:0] word,
    output logic [ADDR_W-1:0] idx,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_addr
);

    search_state_t     state_r;
    search_state_t     next_state_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] idx_next_s;
    logic [DATA_W-1:0] key_r;
    logic [DATA_W-1:0] mask_r;
    logic              load_s;
    logic              hit_s;
    logic              busy_r;
    logic              done_r;
    logic              found_r;
    logic [ADDR_W-1:0] match_addr_r;

    // Next-state, index advance and key-load decision
    always_comb begin
        next_state_s = state_r;
        idx_next_s   = idx_r;
        load_s       = 1'b0;
        hit_s        = (((word ^ key_r) & mask_r) == {DATA_W{1'b0}});
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = SCAN;
                    idx_next_s   = {ADDR_W{1'b0}};
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SCAN: begin
                if (hit_s || (idx_r == {ADDR_W{1'b1}})) begin
                    next_state_s = DONE;
                end else begin
                    idx_next_s = idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
                idx_next_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, latched operands and registered status/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= {ADDR_W{1'b0}};
            key_r        <= {DATA_W{1'b0}};
            mask_r       <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            found_r      <= 1'b0;
            match_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            idx_r   <= idx_next_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= (next_state_s == DONE);
            if (load_s) begin
                key_r  <= key;
                mask_r <= mask;
            end
            // Result only changes when a scan completes, so it holds in between
            if ((state_r == SCAN) && (next_state_s == DONE)) begin
                found_r      <= hit_s;
                match_addr_r <= hit_s ? idx_r : {ADDR_W{1'b0}};
            end
        end
    end

    assign idx        = idx_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign found      = found_r;
    assign match_addr = match_addr_r;

endmodule

// File: rtl/match_sram.sv
// Register file with one write port, one registered read port and a
// background masked-key search engine over the whole array.
module match_sram
    import match_sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              ReadEn,
    input  logic [ADDR_W-1:0] ReadAddr,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadValid,
    input  logic              SearchStart,
    input  logic [DATA_W-1:0] SearchKey,
    input  logic [DATA_W-1:0] SearchMask,
    output logic              SearchBusy,
    output logic              SearchDone,
    output logic              MatchFound,
    output logic [ADDR_W-1:0] MatchAddr
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] Register [DEPTH];
    logic [DATA_W-1:0] read_data_r;
    logic              read_valid_r;
    logic [ADDR_W-1:0] scan_idx_s;
    logic [DATA_W-1:0] scan_word_s;

    // Storage array; deliberately outside the reset domain so contents survive Reset
    always_ff @(posedge Clock) begin
        if (WriteEn) begin
            Register[WriteAddr] <= WriteData;
        end
    end

    // Registered read port; a same-edge write to the read address wins
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            read_data_r  <= {DATA_W{1'b0}};
            read_valid_r <= 1'b0;
        end else begin
            read_valid_r <= ReadEn;
            if (ReadEn) begin
                read_data_r <= (WriteEn && (WriteAddr == ReadAddr)) ? WriteData
                                                                    : Register[ReadAddr];
            end
        end
    end

    assign scan_word_s = Register[scan_idx_s];
    assign ReadData    = read_data_r;
    assign ReadValid   = read_valid_r;

    match_sram_search #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_search (
        .clk        (Clock),
        .rst        (Reset),
        .start      (SearchStart),
        .key        (SearchKey),
        .mask       (SearchMask),
        .word       (scan_word_s),
        .idx        (scan_idx_s),
        .busy       (SearchBusy),
        .done       (SearchDone),
        .found      (MatchFound),
        .match_addr (MatchAddr)
    );

endmodule

// File: tb/tb_match_sram.sv
// Self-checking bench for match_sram: read scoreboard driven by a memory model,
// table of search vectors, and hand sequences for write-first and reset abort.
module tb_match_sram;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        WriteEn = 1'b0;
    logic [3:0]  WriteAddr = 4'd0;
    logic [31:0] WriteData = 32'd0;
    logic        ReadEn = 1'b0;
    logic [3:0]  ReadAddr = 4'd0;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        SearchStart = 1'b0;
    logic [31:0] SearchKey = 32'd0;
    logic [31:0] SearchMask = 32'd0;
    logic        SearchBusy;
    logic        SearchDone;
    logic        MatchFound;
    logic [3:0]  MatchAddr;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [16];
    logic [31:0] sb [$];

    typedef struct {
        logic [31:0] key;
        logic [31:0] mask;
        int          rep_c;
        int          wr_c;
        logic [3:0]  wr_addr;
        logic [31:0] wr_data;
        logic        exp_found;
        logic [3:0]  exp_addr;
        int          exp_done_c;
    } srch_t;

    match_sram #(.DATA_W(32), .ADDR_W(4)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .WriteEn     (WriteEn),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .ReadEn      (ReadEn),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .ReadValid   (ReadValid),
        .SearchStart (SearchStart),
        .SearchKey   (SearchKey),
        .SearchMask  (SearchMask),
        .SearchBusy  (SearchBusy),
        .SearchDone  (SearchDone),
        .MatchFound  (MatchFound),
        .MatchAddr   (MatchAddr)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Sample the read/write ports at the clock edge: push expected read data, update model
    always @(posedge Clock) begin
        if (Reset) begin
            sb.delete();
        end else begin
            if (ReadEn)
                sb.push_back((WriteEn && (WriteAddr == ReadAddr)) ? WriteData : model[ReadAddr]);
            if (WriteEn)
                model[WriteAddr] <= WriteData;
        end
    end

    // Compare read results one cycle after the request
    always @(negedge Clock) begin
        logic [31:0] exp;
        if (!Reset) begin
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("read_valid", {63'd0, ReadValid}, 64'd1);
                chk("read_data", {32'd0, ReadData}, {32'd0, exp});
            end else begin
                chk("read_valid_idle", {63'd0, ReadValid}, 64'd0);
            end
        end
    end

    task automatic run_search(input srch_t v, output int done_c, output int busy_n,
                              output int done_n);
        @(negedge Clock);
        SearchStart = 1'b1;
        SearchKey   = v.key;
        SearchMask  = v.mask;
        done_c = 0;
        busy_n = 0;
        done_n = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            SearchStart = (c == v.rep_c);
            if (c == v.rep_c) SearchKey = 32'h1000_0002;
            WriteEn   = (c == v.wr_c);
            ReadEn    = (c == v.wr_c);
            WriteAddr = v.wr_addr;
            WriteData = v.wr_data;
            ReadAddr  = 4'd5;
            if (SearchBusy) busy_n++;
            if (SearchDone) begin
                done_n++;
                if (done_c == 0) done_c = c;
            end
            if ((done_c != 0) && (c >= done_c + 3)) break;
        end
        SearchStart = 1'b0;
        WriteEn     = 1'b0;
        ReadEn      = 1'b0;
    endtask

    task automatic check_search(input string tag, input srch_t v);
        int done_c, busy_n, done_n;
        run_search(v, done_c, busy_n, done_n);
        chk({tag, "_done_cycle"}, 64'(done_c), 64'(v.exp_done_c));
        chk({tag, "_done_pulses"}, 64'(done_n), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(v.exp_done_c));
        chk({tag, "_found"}, {63'd0, MatchFound}, {63'd0, v.exp_found});
        chk({tag, "_addr"}, {60'd0, MatchAddr}, {60'd0, v.exp_addr});
    endtask

    task automatic read_all();
        for (int k = 0; k < 16; k++) begin
            @(negedge Clock);
            ReadEn   = 1'b1;
            ReadAddr = 4'(k);
        end
        @(negedge Clock);
        ReadEn = 1'b0;
    endtask

    srch_t tbl [7];

    initial begin
        int seen_done;
        srch_t fresh;

        tbl[0] = '{32'h1000_0009, 32'hFFFF_FFFF, 0, 0, 4'd0, 32'd0, 1'b1, 4'd9, 11};
        tbl[1] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0, 4'd0, 32'd0, 1'b0, 4'd0, 17};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 0, 0, 4'd0, 32'd0, 1'b1, 4'd0, 2};
        tbl[3] = '{32'h1000_000F, 32'hFFFF_FFFF, 0, 0, 4'd0, 32'd0, 1'b1, 4'd15, 17};
        tbl[4] = '{32'h0000_0002, 32'h0000_0003, 0, 0, 4'd0, 32'd0, 1'b1, 4'd2, 4};
        tbl[5] = '{32'h1000_0009, 32'hFFFF_FFFF, 3, 0, 4'd0, 32'd0, 1'b1, 4'd9, 11};
        tbl[6] = '{32'hBBBB_0000, 32'hFFFF_0000, 0, 2, 4'd12, 32'hBBBB_1234, 1'b1, 4'd12, 14};

        #12;
        chk("rst_read_data", {32'd0, ReadData}, 64'd0);
        chk("rst_read_valid", {63'd0, ReadValid}, 64'd0);
        chk("rst_busy", {63'd0, SearchBusy}, 64'd0);
        chk("rst_done", {63'd0, SearchDone}, 64'd0);
        chk("rst_found", {63'd0, MatchFound}, 64'd0);
        chk("rst_addr", {60'd0, MatchAddr}, 64'd0);
        @(negedge Clock);
        Reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            @(negedge Clock);
            WriteEn   = 1'b1;
            WriteAddr = 4'(k);
            WriteData = 32'h1000_0000 + 32'(k);
        end
        @(negedge Clock);
        WriteEn = 1'b0;
        read_all();

        for (int i = 0; i < 7; i++)
            check_search($sformatf("search%0d", i), tbl[i]);

        // Write-first collision, then a masked search that must find it
        @(negedge Clock);
        WriteEn   = 1'b1;
        WriteAddr = 4'd3;
        WriteData = 32'hAAAA_5555;
        ReadEn    = 1'b1;
        ReadAddr  = 4'd3;
        @(negedge Clock);
        WriteEn = 1'b0;
        ReadEn  = 1'b0;
        chk("write_first", {32'd0, ReadData}, 64'hAAAA_5555);
        fresh = '{32'hAAAA_0000, 32'hFFFF_0000, 0, 0, 4'd0, 32'd0, 1'b1, 4'd3, 5};
        check_search("wf_search", fresh);

        // Reset in the middle of a scan aborts it silently
        @(negedge Clock);
        SearchStart = 1'b1;
        SearchKey   = 32'hDEAD_BEEF;
        SearchMask  = 32'hFFFF_FFFF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge Clock);
            SearchStart = 1'b0;
        end
        Reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, SearchBusy}, 64'd0);
        chk("abort_done", {63'd0, SearchDone}, 64'd0);
        chk("abort_found", {63'd0, MatchFound}, 64'd0);
        chk("abort_addr", {60'd0, MatchAddr}, 64'd0);
        chk("abort_read_data", {32'd0, ReadData}, 64'd0);
        chk("abort_read_valid", {63'd0, ReadValid}, 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clock);
            if (SearchDone) seen_done++;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        read_all();
        check_search("post_reset", tbl[0]);

        repeat (3) @(negedge Clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_sram.md
MATCH_SRAM -- requirements
Module: match_sram

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits.
REQ-002 Parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words (default 16).
REQ-003 Clock  input  1  single rising-edge clock for all state.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 WriteEn  input  1  write strobe, sampled on Clock rise.
REQ-006 WriteAddr  input  ADDR_W  write address.
REQ-007 WriteData  input  DATA_W  write data.
REQ-008 ReadEn  input  1  read request.
REQ-009 ReadAddr  input  ADDR_W  read address.
REQ-010 ReadData  output  DATA_W  registered read data.
REQ-011 ReadValid  output  1  one-cycle pulse; ReadData is valid.
REQ-012 SearchStart  input  1  begins a key search; honoured only when idle.
REQ-013 SearchKey  input  DATA_W  compare key, latched at start.
REQ-014 SearchMask  input  DATA_W  compare mask, latched at start; 1 = bit compared.
REQ-015 SearchBusy  output  1  high while a scan is in progress.
REQ-016 SearchDone  output  1  one-cycle pulse at end of search.
REQ-017 MatchFound  output  1  result of the last completed search.
REQ-018 MatchAddr  output  ADDR_W  lowest matching address of the last completed search.
REQ-019 The storage array SHALL be named Register, be DEPTH x DATA_W, and be loadable by $readmemh from a hierarchical path.

Function
REQ-020 When WriteEn=1 at a Clock rise, Register[WriteAddr] SHALL take WriteData, with the new value visible from the next cycle.
REQ-021 When ReadEn=1 at rise N, ReadData SHALL hold Register[ReadAddr] after rise N and ReadValid SHALL be 1 for exactly that cycle. When ReadEn=0, ReadData SHALL hold its value.
REQ-022 A read and a write to the same address on the same edge SHALL be write-first: ReadData returns WriteData.
REQ-023 The search FSM SHALL have three states: IDLE -> SCAN on SearchStart; SCAN -> DONE on a hit or when idx=DEPTH-1; DONE -> IDLE unconditionally.
REQ-024 On entering SCAN, the FSM SHALL latch the key and mask and set idx=0. Each SCAN cycle SHALL test ((Register[idx] ^ key) & mask) == 0 and otherwise increment idx.
REQ-025 On a hit at idx i, the FSM SHALL set MatchFound=1 and MatchAddr=i. On a miss through DEPTH-1, it SHALL set MatchFound=0 and MatchAddr=0.
REQ-026 Latency: with SearchStart sampled at rise 0, SearchDone SHALL be high in cycle i+2 for a hit at index i, and in cycle DEPTH+1 for a miss.
REQ-027 SearchBusy SHALL be 1 in SCAN and DONE only.
REQ-028 MatchFound and MatchAddr SHALL hold until the next search completes.
REQ-029 SearchStart SHALL be ignored when the FSM is not in IDLE.
REQ-030 A write during a scan SHALL be seen by any compare on a later cycle. Reads SHALL operate concurrently with a scan.
REQ-031 With SearchMask=0, the search SHALL hit at index 0.

Reset
REQ-032 Reset SHALL asynchronously force IDLE, idx=0, ReadData=0, ReadValid=0, SearchBusy=0, SearchDone=0, MatchFound=0, MatchAddr=0.
REQ-033 Register contents SHALL NOT be cleared by Reset.
REQ-034 Reset during a scan SHALL abort it with no SearchDone pulse.

Structure
REQ-035 Package match_sram_pkg SHALL hold the FSM state encodings (IDLE, SCAN, DONE) and the default DATA_W and ADDR_W.
REQ-036 The scan FSM SHALL be the sub-module match_sram_search, which drives idx to the array and receives Register[idx].

Verification
REQ-037 Load the hex file with word k = 0x1000_0000+k, then read addresses 0..15 back-to-back -> ReadData = 0x1000_000k one cycle later, ReadValid high each cycle.
REQ-038 Search key 0x1000_0009 with mask 0xFFFF_FFFF -> MatchFound=1, MatchAddr=9, SearchDone in cycle 11.
REQ-039 Search key 0xDEAD_BEEF with full mask -> MatchFound=0, MatchAddr=0, SearchDone in cycle 17, SearchBusy high cycles 1-17.
REQ-040 Write 0xAAAA_5555 to address 3 while reading address 3 -> ReadData=0xAAAA_5555. Then search key 0xAAAA_0000 with mask 0xFFFF_0000 -> MatchAddr=3.
REQ-041 Assert Reset in cycle 4 of a scan -> all outputs 0, no SearchDone, memory intact. A fresh SearchStart then completes normally.
REQ-042 SearchStart pulsed again mid-scan -> ignored; the first result is reported once.
